mempool_dma_arbiter: RTL

Shares the cluster's single DMA request port (`dma_req_t` / `dma_meta_t` path into the split and distributed midends) among `NumReq` requesters, such as core-side DMA frontends or a host debug port. Grants are round-robin and locked per request. Every issued transfer's requester ID is recorded in order. Each `trans_complete` pulse from the midend is routed back as a per-requester `done_o` pulse, so software on each requester can wait on its own transfers.

---
 rtl/mempool_pkg.sv | 24 ++
 rtl/mempool_dma_arbiter_fifo_v3.sv | 49 ++++
 rtl/mempool_dma_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mempool_pkg.sv
// Shared DMA descriptor/metadata types and small helpers for the MemPool DMA path.
package mempool_pkg;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } dma_req_t;

  typedef struct packed {
    logic backend_idle;
    logic trans_complete;
  } dma_meta_t;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mempool_dma_arbiter_fifo_v3.sv
// In-order ID FIFO (fifo_v3 interface subset) with synchronous active-low reset.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrDepth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AddrDepth:0]    cnt_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == (AddrDepth+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  // Full/empty are taken from occupancy before this cycle's update.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mempool_dma_arbiter.sv
// Round-robin, per-request-locked arbiter sharing one DMA request port; routes
// in-order completions back to the issuing requester as done pulses.
module mempool_dma_arbiter
  import mempool_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  dma_req_t [NumReq-1:0] req_i,
  input  logic     [NumReq-1:0] req_valid_i,
  output logic     [NumReq-1:0] req_ready_o,
  output logic     [NumReq-1:0] done_o,
  output dma_req_t              dma_req_o,
  output logic                  dma_req_valid_o,
  input  logic                  dma_req_ready_i,
  input  dma_meta_t             dma_meta_i,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam int unsigned IdWidth = idx_width(NumReq);
  typedef logic [IdWidth-1:0] id_t;

  // Returns {found, idx}: first valid requester at or after ptr, wrapping.
  function automatic logic [IdWidth:0] rr_pick(input logic [NumReq-1:0] vld, input id_t ptr);
    logic found;
    id_t  idx;
    int   j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      j = (int'(ptr) + i) % int'(NumReq);
      if (!found && vld[j]) begin
        found = 1'b1;
        idx   = id_t'(j);
      end
    end
    return {found, idx};
  endfunction

  arb_state_e        state_q;
  id_t               lock_idx_q, rr_ptr_q;
  logic [NumReq-1:0] done_q;
  logic              err_q;

  logic [IdWidth:0]  pick;
  id_t               grant_idx, head, rr_next;
  logic              fire, pop, fifo_full, fifo_empty;

  always_comb begin
    pick            = rr_pick(req_valid_i, rr_ptr_q);
    grant_idx       = pick[IdWidth-1:0];
    dma_req_valid_o = 1'b0;
    if (state_q == ArbLocked) begin
      grant_idx       = lock_idx_q;
      dma_req_valid_o = 1'b1;
    end else begin
      dma_req_valid_o = pick[IdWidth] & ~fifo_full;
    end
    // No grant while reset is held, so nothing is pushed or handed downstream.
    dma_req_valid_o = dma_req_valid_o & rst_ni;
  end

  assign dma_req_o = dma_req_valid_o ? req_i[grant_idx] : '0;
  assign fire      = dma_req_valid_o & dma_req_ready_i;
  assign pop       = dma_meta_i.trans_complete & ~fifo_empty;
  assign rr_next   = (grant_idx == id_t'(NumReq-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < int'(NumReq); i++) req_ready_o[i] = fire && (grant_idx == id_t'(i));
  end

  fifo_v3 #(
    .DATA_WIDTH (IdWidth),
    .DEPTH      (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (grant_idx),
    .push_i  (fire),
    .data_o  (head),
    .pop_i   (pop)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      done_q <= '0;
      if (pop) done_q[head] <= 1'b1;
      if (dma_meta_i.trans_complete && fifo_empty) err_q <= 1'b1;
      if (fire) rr_ptr_q <= rr_next;
      case (state_q)
        ArbIdle: if (dma_req_valid_o && !dma_req_ready_i) begin
          state_q    <= ArbLocked;
          lock_idx_q <= grant_idx;
        end
        ArbLocked: if (dma_req_ready_i) state_q <= ArbIdle;
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;
  assign idle_o = fifo_empty & dma_meta_i.backend_idle & ~|req_valid_i;

endmodule
